// File: rtl/bitmap_row_scanner.sv
// Reads a 1-bpp bitmap from a combinational image ROM one row at a time and
// streams it out pixel by pixel, top row first, MSB first.
module bitmap_row_scanner #(
  parameter int ROWS   = 48,
  parameter int COLS   = 64,
  parameter int ADDR_W = 6,
  parameter int X_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COLS-1:0]   rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic [X_W-1:0]    pix_x,
  output logic [ADDR_W-1:0] pix_y,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [X_W-1:0]    LAST_X   = X_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [COLS-1:0]   shreg_q, shreg_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      x_q     <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      shreg_q <= shreg_d;
    end
  end

  // Handshake: a pixel moves on every cycle where pix_valid && pix_ready.
  // Once pix_valid rises it stays high with data, position and flags frozen
  // until that transfer happens.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    x_d     = x_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          x_d     = '0;
        end
      end
      FETCH: begin
        shreg_d = rom_data;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (pix_ready) begin
          shreg_d = {shreg_q[COLS-2:0], 1'b0};
          if (x_q == LAST_X) begin
            x_d = '0;
            if (addr_q == LAST_ROW) begin
              state_d = DONE;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = FETCH;
            end
          end else begin
            x_d = x_q + X_W'(1);
          end
        end
      end
      DONE: begin
        addr_d  = '0;
        x_d     = '0;
        state_d = loop ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The address register doubles as the current row, so pix_y needs no copy.
  assign rom_addr  = addr_q;
  assign pix_valid = (state_q == SHIFT);
  assign pix_data  = pix_valid & shreg_q[COLS-1];
  assign pix_x     = x_q;
  assign pix_y     = addr_q;
  assign pix_eol   = pix_valid && (x_q == LAST_X);
  assign pix_eof   = pix_eol && (addr_q == LAST_ROW);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bitmap_row_scanner.sv
// Directed bench for bitmap_row_scanner: ROM model, transfer monitor and a
// linear sequence of frame scans with immediate assertions.
module tb_bitmap_row_scanner;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk = 1'b0;
  logic        rst, start, loop, pix_ready;
  logic [5:0]  rom_addr, pix_y, pix_x;
  logic [63:0] rom_data;
  logic        pix_valid, pix_data, pix_eol, pix_eof, busy, done;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitmap_row_scanner dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  function automatic logic [63:0] rom_word(input logic [5:0] a);
    if (a == 6'd0) return 64'h1800_0F83_E1F8_3E0F;
    else if (a == 6'd15) return {64{1'b1}};
    else return {a, 2'b10, 24'hC35A96 ^ {4{a}}, 32'h0F1E_2D3C + {26'd0, a}};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfer monitor: position model, per-pixel checks, stall stability, stats.
  int          cyc = 0, mon_x = 0, mon_y = 0;
  int          trans_cnt = 0, eol_cnt = 0, eof_cnt = 0, done_cnt = 0;
  int          ones15 = 0, frames_seen = 0, fetch_cyc = 0, done_cyc = 0;
  logic [1:0]  prev_state = S_IDLE;
  logic        stall_prev = 1'b0, prev_data = 1'b0, prev_eol = 1'b0;
  logic [5:0]  prev_x = '0, prev_y = '0;
  logic [3071:0] frame_bits = '0, last_frame = '0;

  initial begin
    logic [63:0] word;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_x = 0;
        mon_y = 0;
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("stall_valid", 64'(pix_valid), 64'd1);
          check("stall_data", 64'(pix_data), 64'(prev_data));
          check("stall_x", 64'(pix_x), 64'(prev_x));
          check("stall_y", 64'(pix_y), 64'(prev_y));
          check("stall_eol", 64'(pix_eol), 64'(prev_eol));
        end
        if (dbg_state == S_FETCH && (prev_state == S_IDLE || prev_state == S_DONE))
          fetch_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (pix_valid && pix_ready) begin
          word = rom_word(6'(mon_y));
          check("px_data", 64'(pix_data), 64'(word[63-mon_x]));
          check("px_x", 64'(pix_x), 64'(mon_x));
          check("px_y", 64'(pix_y), 64'(mon_y));
          check("px_eol", 64'(pix_eol), 64'(mon_x == 63));
          check("px_eof", 64'(pix_eof), 64'(mon_x == 63 && mon_y == 47));
          frame_bits[mon_y*64 + mon_x] = pix_data;
          trans_cnt++;
          if (pix_eol) eol_cnt++;
          if (pix_eof) eof_cnt++;
          if (mon_y == 15 && pix_data) ones15++;
          if (mon_x == 63) begin
            mon_x = 0;
            if (mon_y == 47) begin
              mon_y = 0;
              last_frame = frame_bits;
              frames_seen++;
            end else begin
              mon_y++;
            end
          end else begin
            mon_x++;
          end
        end
        stall_prev = pix_valid && !pix_ready;
        prev_data  = pix_data;
        prev_x     = pix_x;
        prev_y     = pix_y;
        prev_eol   = pix_eol;
      end
      prev_state = dbg_state;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic pulse_start;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic settle;
    @(posedge clk); #1;
  endtask

  task automatic run_until_done(input bit bp, input int budget, input bit watch_busy,
                                output bit ok, output int busy_drops);
    ok = 1'b0;
    busy_drops = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (watch_busy && !busy) busy_drops++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit          ok;
    int          drops, drops2, b_trans, b_eol, b_eof, b_done, b_ones, b_frames;
    logic [7:0]  first8;
    logic [3071:0] ref_frame;
    logic [63:0] row0;

    rst = 1'b1; start = 1'b0; loop = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({pix_valid, pix_data, pix_eol, pix_eof, busy, done, pix_x, pix_y, rom_addr, dbg_state}),
          64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Idle with start low
    drops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({pix_valid, pix_data, pix_eol, pix_eof, busy, done, pix_x, pix_y, rom_addr} != '0) drops++;
    end
    check("idle_quiet_cycles", 64'(drops), 64'd0);

    // Frame 1: pix_ready held high
    pix_ready = 1'b1;
    settle();
    b_trans = trans_cnt; b_eol = eol_cnt; b_eof = eof_cnt; b_done = done_cnt;
    b_ones = ones15; b_frames = frames_seen;
    pulse_start();
    @(negedge clk);
    check("start_fetch_state", 64'(dbg_state), 64'(S_FETCH));
    check("start_fetch_novalid", 64'(pix_valid), 64'd0);
    check("start_rom_addr", 64'(rom_addr), 64'd0);
    first8 = 8'b0001_1000;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      check("first_valid", 64'(pix_valid), 64'd1);
      check("first8_data", 64'(pix_data), 64'(first8[7-i]));
      check("first8_x", 64'(pix_x), 64'(i));
    end
    run_until_done(1'b0, 4000, 1'b0, ok, drops);
    check("frame1_done_seen", 64'(ok), 64'd1);
    settle();
    check("frame1_cycles", 64'(done_cyc - fetch_cyc + 1), 64'd3121);
    check("frame1_transfers", 64'(trans_cnt - b_trans), 64'd3072);
    check("frame1_eol_count", 64'(eol_cnt - b_eol), 64'd48);
    check("frame1_eof_count", 64'(eof_cnt - b_eof), 64'd1);
    check("frame1_row15_ones", 64'(ones15 - b_ones), 64'd64);
    check("frame1_frames", 64'(frames_seen - b_frames), 64'd1);
    ref_frame = last_frame;
    repeat (5) @(posedge clk);
    #1;
    check("frame1_done_once", 64'(done_cnt - b_done), 64'd1);
    check("frame1_idle_after", 64'(dbg_state), 64'(S_IDLE));
    check("frame1_busy_after", 64'(busy), 64'd0);
    check("frame1_addr_after", 64'(rom_addr), 64'd0);

    // Frame 2: random backpressure
    settle();
    b_trans = trans_cnt; b_done = done_cnt;
    pulse_start();
    run_until_done(1'b1, 12000, 1'b0, ok, drops);
    check("bp_done_seen", 64'(ok), 64'd1);
    pix_ready = 1'b1;
    settle();
    check("bp_transfers", 64'(trans_cnt - b_trans), 64'd3072);
    check("bp_frame_match", 64'(last_frame == ref_frame), 64'd1);
    check("bp_done_once", 64'(done_cnt - b_done), 64'd1);

    // Loop mode: two back-to-back frames
    loop = 1'b1;
    settle();
    b_trans = trans_cnt; b_done = done_cnt; b_frames = frames_seen;
    pulse_start();
    run_until_done(1'b0, 4000, 1'b1, ok, drops);
    check("loop_done1_seen", 64'(ok), 64'd1);
    check("loop_busy_in_done", 64'(busy), 64'd1);
    @(negedge clk);
    check("loop_refetch_state", 64'(dbg_state), 64'(S_FETCH));
    check("loop_refetch_addr", 64'(rom_addr), 64'd0);
    check("loop_refetch_busy", 64'(busy), 64'd1);
    run_until_done(1'b0, 4000, 1'b1, ok, drops2);
    loop = 1'b0;
    start = 1'b1;
    check("loop_done2_seen", 64'(ok), 64'd1);
    check("loop_busy_drops", 64'(drops + drops2), 64'd0);
    @(negedge clk);
    check("done_ignores_start", 64'(dbg_state), 64'(S_IDLE));
    start = 1'b0;
    settle();
    check("loop_frames", 64'(frames_seen - b_frames), 64'd2);
    check("loop_transfers", 64'(trans_cnt - b_trans), 64'd6144);
    check("loop_done_count", 64'(done_cnt - b_done), 64'd2);
    check("loop_frame_match", 64'(last_frame == ref_frame), 64'd1);

    // Reset in the middle of a scan at (20, 5)
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pix_valid && pix_x == 6'd20 && pix_y == 6'd5) begin
        ok = 1'b1;
        break;
      end
    end
    check("midscan_reached", 64'(ok), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midscan_rst_valid", 64'(pix_valid), 64'd0);
    check("midscan_rst_state", 64'(dbg_state), 64'(S_IDLE));
    check("midscan_rst_addr", 64'(rom_addr), 64'd0);
    check("midscan_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    settle();
    b_trans = trans_cnt; b_done = done_cnt;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    row0 = rom_word(6'd0);
    check("replay_valid", 64'(pix_valid), 64'd1);
    check("replay_x", 64'(pix_x), 64'd0);
    check("replay_y", 64'(pix_y), 64'd0);
    check("replay_data", 64'(pix_data), 64'(row0[63]));
    run_until_done(1'b0, 4000, 1'b0, ok, drops);
    check("replay_done_seen", 64'(ok), 64'd1);
    settle();
    check("replay_transfers", 64'(trans_cnt - b_trans), 64'd3072);
    check("replay_frame_match", 64'(last_frame == ref_frame), 64'd1);
    check("replay_done_once", 64'(done_cnt - b_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
